bi_channel_ctrl: RTL and testbench

//  Direction controller for one bidirectional 32-bit inter-router link.

---
 rtl/bi_channel_ctrl_if.sv | 23 ++
 rtl/bi_channel_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bi_channel_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bi_channel_ctrl_if.sv
// Signal bundle between the two link-end routers and the bi-directional channel controller.
// master = router side (requests/tails), slave = controller side (selects/grants/owner).
interface bi_channel_ctrl_if;
  logic       req1;
  logic       req2;
  logic       tail1;
  logic       tail2;
  logic       inout_select1;
  logic       inout_select2;
  logic       gnt1;
  logic       gnt2;
  logic [1:0] owner;

  modport master (
    output req1, req2, tail1, tail2,
    input  inout_select1, inout_select2, gnt1, gnt2, owner
  );

  modport slave (
    input  req1, req2, tail1, tail2,
    output inout_select1, inout_select2, gnt1, gnt2, owner
  );
endinterface

// File: rtl/bi_channel_ctrl.sv
// Direction controller for one bidirectional inter-router link with a turnaround gap on every release.
// Optional packet-count preemption of a busy owner is enabled by defining BICH_PREEMPT_EN.
//
// state | meaning
// IDLE  | nobody drives the link, arbitrate every cycle
// OWN1  | end1 drives the link
// OWN2  | end2 drives the link
// TURN  | bus turnaround, neither end drives for TURN_CYCLES cycles
module bi_channel_ctrl #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_PKTS    = 4
) (
  input logic              clk,
  input logic              rst,
  bi_channel_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN1 = 2'b01,
    OWN2 = 2'b10,
    TURN = 2'b11
  } state_t;

  localparam int          TW        = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

  state_t        state_q, state_d;
  state_t        arb_state;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;
  logic          lw_q, lw_d;  // last winner: 0 = end1, 1 = end2
  logic          sel1_q, sel1_d;
  logic          sel2_q, sel2_d;
  logic          gnt1_q, gnt1_d;
  logic          gnt2_q, gnt2_d;

`ifdef BICH_PREEMPT_EN
  localparam int          PW       = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(MAX_PKTS - 1);

  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
`else
  localparam int unused_max_pkts = MAX_PKTS;
  logic          unused_tail;

  assign unused_tail = bus.tail1 ^ bus.tail2;
`endif

  always_comb begin
    arb_state = IDLE;
    if (bus.req1 && bus.req2) arb_state = lw_q ? OWN1 : OWN2;
    else if (bus.req1)        arb_state = OWN1;
    else if (bus.req2)        arb_state = OWN2;
  end

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    lw_d       = lw_q;
`ifdef BICH_PREEMPT_EN
    pkt_cnt_d  = pkt_cnt_q;
`endif

    case (state_q)
      IDLE: state_d = arb_state;
      OWN1: begin
        if (!bus.req1) begin
          state_d    = TURN;
          turn_cnt_d = TURN_LOAD;
        end
`ifdef BICH_PREEMPT_EN
        else if (bus.tail1) begin
          if (pkt_cnt_q == PKT_LAST) begin
            if (bus.req2) begin
              state_d    = TURN;
              turn_cnt_d = TURN_LOAD;
            end
          end else begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end
`endif
      end
      OWN2: begin
        if (!bus.req2) begin
          state_d    = TURN;
          turn_cnt_d = TURN_LOAD;
        end
`ifdef BICH_PREEMPT_EN
        else if (bus.tail2) begin
          if (pkt_cnt_q == PKT_LAST) begin
            if (bus.req1) begin
              state_d    = TURN;
              turn_cnt_d = TURN_LOAD;
            end
          end else begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end
`endif
      end
      TURN: begin
        if (turn_cnt_q == '0) state_d = arb_state;
        else                  turn_cnt_d = turn_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A fresh grant records the winner so the other end wins the next tie.
    if (state_d == OWN1 && state_q != OWN1) begin
      lw_d = 1'b0;
`ifdef BICH_PREEMPT_EN
      pkt_cnt_d = '0;
`endif
    end
    if (state_d == OWN2 && state_q != OWN2) begin
      lw_d = 1'b1;
`ifdef BICH_PREEMPT_EN
      pkt_cnt_d = '0;
`endif
    end

    sel1_d = (state_d == OWN1);
    gnt1_d = (state_d == OWN1);
    sel2_d = (state_d == OWN2);
    gnt2_d = (state_d == OWN2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      turn_cnt_q <= '0;
      lw_q       <= 1'b1;
      sel1_q     <= 1'b0;
      sel2_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      gnt2_q     <= 1'b0;
`ifdef BICH_PREEMPT_EN
      pkt_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      lw_q       <= lw_d;
      sel1_q     <= sel1_d;
      sel2_q     <= sel2_d;
      gnt1_q     <= gnt1_d;
      gnt2_q     <= gnt2_d;
`ifdef BICH_PREEMPT_EN
      pkt_cnt_q  <= pkt_cnt_d;
`endif
    end
  end

  assign bus.inout_select1 = sel1_q;
  assign bus.inout_select2 = sel2_q;
  assign bus.gnt1          = gnt1_q;
  assign bus.gnt2          = gnt2_q;
  assign bus.owner         = state_q;

endmodule

// File: tb/tb_bi_channel_ctrl.sv
// Scoreboard bench for bi_channel_ctrl: directed scenarios plus a random stress run against a reference model.
// Build with BICH_PREEMPT_EN defined or not; expectations follow the same macro.
module tb_bi_channel_ctrl;
  localparam int TURN   = 1;
  localparam int MAXP   = 4;
  localparam int STARVE = 300;
`ifdef BICH_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  // {owner, select1, select2, gnt1, gnt2}
  localparam logic [5:0] E_IDLE = 6'b00_0000;
  localparam logic [5:0] E_OWN1 = 6'b01_1010;
  localparam logic [5:0] E_OWN2 = 6'b10_0101;
  localparam logic [5:0] E_TURN = 6'b11_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bi_channel_ctrl_if bus ();

  bi_channel_ctrl #(.TURN_CYCLES(TURN), .MAX_PKTS(MAXP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [5:0] sb[$];
  logic [5:0] mon_exp;
  string      phase = "reset";

  int m_state, m_lw, m_pkt, m_turn;

  function automatic logic [5:0] act_out();
    return {bus.owner, bus.inout_select1, bus.inout_select2, bus.gnt1, bus.gnt2};
  endfunction

  // Scoreboard consumer: one expected output vector per clock edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_exp = sb.pop_front();
      checks++;
      if (act_out() !== mon_exp) begin
        errors++;
        $display("FAIL sb_%s t=%0t: got %b expected %b", phase, $time, act_out(), mon_exp);
      end
    end
    checks++;
    if ((bus.inout_select1 & bus.inout_select2) !== 1'b0) begin
      errors++;
      $display("FAIL both_select t=%0t: sel1=%b sel2=%b expected not both 1", $time,
               bus.inout_select1, bus.inout_select2);
    end
  end

  task automatic drive(input logic r1, input logic r2, input logic t1, input logic t2);
    bus.req1  = r1;
    bus.req2  = r2;
    bus.tail1 = t1;
    bus.tail2 = t2;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic [5:0] e);
    sb.push_back(e);
    tick();
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  function automatic int pick(input logic r1, input logic r2);
    if (r1 && r2) return (m_lw == 2) ? 1 : 2;
    if (r1) return 1;
    if (r2) return 2;
    return 0;
  endfunction

  task automatic model_step(input logic r1, input logic r2, input logic t1, input logic t2);
    int nxt;
    nxt = m_state;
    case (m_state)
      0: nxt = pick(r1, r2);
      1: begin
        if (!r1) begin
          nxt = 3; m_turn = 0;
        end else if (PREEMPT && t1) begin
          if (m_pkt >= MAXP - 1) begin
            if (r2) begin nxt = 3; m_turn = 0; end
          end else m_pkt++;
        end
      end
      2: begin
        if (!r2) begin
          nxt = 3; m_turn = 0;
        end else if (PREEMPT && t2) begin
          if (m_pkt >= MAXP - 1) begin
            if (r1) begin nxt = 3; m_turn = 0; end
          end else m_pkt++;
        end
      end
      default: begin
        m_turn++;
        if (m_turn >= TURN) nxt = pick(r1, r2);
      end
    endcase
    if (nxt == 1 && m_state != 1) begin m_lw = 1; m_pkt = 0; end
    if (nxt == 2 && m_state != 2) begin m_lw = 2; m_pkt = 0; end
    m_state = nxt;
  endtask

  function automatic logic [5:0] m_out();
    case (m_state)
      0:       return E_IDLE;
      1:       return E_OWN1;
      2:       return E_OWN2;
      default: return E_TURN;
    endcase
  endfunction

  task automatic test_reset();
    phase = "reset";
    drive(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    checks++;
    if (act_out() !== E_IDLE) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", act_out(), E_IDLE);
    end
    tick();
    checks++;
    if (act_out() !== E_IDLE) begin
      errors++;
      $display("FAIL reset_clocked: got %b expected %b", act_out(), E_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_grant();
    phase = "basic";
    apply_reset();
    drive(1, 0, 0, 0);
    cyc(E_OWN1); cyc(E_OWN1); cyc(E_OWN1);
    drive(0, 0, 0, 0);
    cyc(E_TURN); cyc(E_IDLE); cyc(E_IDLE);
  endtask

  task automatic test_round_robin();
    phase = "rr";
    apply_reset();
    drive(1, 1, 0, 0);
    cyc(E_OWN1); cyc(E_OWN1);
    drive(0, 1, 0, 0);
    cyc(E_TURN); cyc(E_OWN2); cyc(E_OWN2);
    drive(1, 1, 0, 0);
    cyc(E_OWN2);
    drive(1, 0, 0, 0);
    cyc(E_TURN); cyc(E_OWN1);
    drive(0, 1, 0, 0);
    cyc(E_TURN); cyc(E_OWN2);
    drive(0, 0, 0, 0);
    cyc(E_TURN); cyc(E_IDLE);
    drive(1, 1, 0, 0);
    cyc(E_OWN1);
    drive(0, 0, 0, 0);
    cyc(E_TURN); cyc(E_IDLE);
    drive(1, 1, 0, 0);
    cyc(E_OWN2);
    drive(0, 0, 0, 0);
    cyc(E_TURN); cyc(E_IDLE);
  endtask

  task automatic test_release_idle();
    phase = "release";
    apply_reset();
    drive(0, 1, 0, 0);
    cyc(E_OWN2);
    drive(0, 0, 0, 0);
    cyc(E_TURN); cyc(E_IDLE); cyc(E_IDLE);
    drive(1, 0, 0, 0);
    cyc(E_OWN1);
    drive(0, 0, 1, 1);
    cyc(E_TURN); cyc(E_IDLE); cyc(E_IDLE);
    drive(1, 0, 0, 0);
    cyc(E_OWN1);
    drive(0, 0, 1, 0);
    cyc(E_TURN); cyc(E_IDLE);
  endtask

  task automatic test_async_reset();
    phase = "async_rst";
    apply_reset();
    drive(1, 0, 1, 0);
    cyc(E_OWN1); cyc(E_OWN1);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (act_out() !== E_IDLE) begin
      errors++;
      $display("FAIL async_reset_mid_packet: got %b expected %b", act_out(), E_IDLE);
    end
    #1 rst = 1'b0;
    drive(0, 1, 0, 0);
    cyc(E_OWN2); cyc(E_OWN2);
    drive(0, 0, 0, 0);
    cyc(E_TURN); cyc(E_IDLE);
  endtask

  task automatic test_preempt();
    phase = "preempt";
    apply_reset();
    drive(1, 1, 0, 0);
    cyc(E_OWN1);
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 1, 0);
      cyc((PREEMPT && k == 4) ? E_TURN : E_OWN1);
      if (k < 4) begin
        drive(1, 1, 0, 0);
        cyc(E_OWN1);
      end
    end
`ifdef BICH_PREEMPT_EN
    drive(1, 1, 0, 0);
    cyc(E_OWN2);
    drive(1, 0, 0, 0);
    cyc(E_TURN); cyc(E_OWN1);
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 1, 0);
      cyc(E_OWN1);
    end
    drive(1, 1, 1, 0);
    cyc(E_TURN);
    drive(1, 1, 0, 0);
    cyc(E_OWN2);
    drive(0, 0, 0, 0);
    cyc(E_TURN); cyc(E_IDLE);
`else
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 1, 0);
      cyc(E_OWN1);
    end
    drive(0, 1, 0, 0);
    cyc(E_TURN); cyc(E_OWN2);
    drive(0, 0, 0, 0);
    cyc(E_TURN); cyc(E_IDLE);
`endif
  endtask

  task automatic test_stress();
    logic       r1, r2, t1, t2;
    logic [1:0] po, cur;
    int         run, w1, w2, max_w;
    phase = "stress";
    apply_reset();
    m_state = 0; m_lw = 2; m_pkt = 0; m_turn = 0;
    r1 = 0; r2 = 0; po = 2'b00; run = 0; w1 = 0; w2 = 0; max_w = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) r1 = ~r1;
      if ($urandom_range(7) == 0) r2 = ~r2;
      t1 = ($urandom_range(2) == 0);
      t2 = ($urandom_range(2) == 0);
      drive(r1, r2, t1, t2);
      model_step(r1, r2, t1, t2);
      cyc(m_out());
      cur = bus.owner;
      if (cur == 2'b11) begin
        run++;
      end else begin
        if (po == 2'b11) begin
          checks++;
          if (run < TURN) begin
            errors++;
            $display("FAIL turn_gap t=%0t: got %0d turn cycles expected >= %0d", $time, run, TURN);
          end
        end else if (po != 2'b00) begin
          checks++;
          if (cur != po) begin
            errors++;
            $display("FAIL owner_skip t=%0t: got owner %b after %b expected 11 in between", $time, cur, po);
          end
        end
        run = 0;
      end
      po = cur;
      w1 = (bus.req1 && !bus.gnt1) ? w1 + 1 : 0;
      w2 = (bus.req2 && !bus.gnt2) ? w2 + 1 : 0;
      if (w1 > max_w) max_w = w1;
      if (w2 > max_w) max_w = w2;
    end
`ifdef BICH_PREEMPT_EN
    checks++;
    if (max_w > STARVE) begin
      errors++;
      $display("FAIL starvation: got wait %0d cycles expected <= %0d", max_w, STARVE);
    end
`endif
    drive(0, 0, 0, 0);
    tick(); tick(); tick();
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0);
    rst = 1'b1;
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_release_idle();
    test_async_reset();
    test_preempt();
    test_stress();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d leftover expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
